status_array_regs: RTL and testbench
====================================

// Module: status_array_regs
// PURPOSE
//  Parametrised register block for an array of NUM_STATUS status registers, each backed by a
//  per-channel IDLE/BUSY state machine driven by hardware start/done pulses. Exposes the
//  array on a req/gnt/rvalid register bus at BASE_ADDR with STRIDE-byte spacing. Adds a busy-cycle
//  counter, a sticky W1C done flag and a maskable interrupt per channel.
// PARAMETERS
//  NUM_STATUS  2          number of status channels (1..64)
//  BASE_ADDR   64'h0      byte address of status[0]
//  STRIDE      64'h4      byte spacing between channels; fixed at 4 (one 32-bit word)
//  ADDR_WIDTH  64         bus address width
//  CNT_WIDTH   24         busy counter width (<= 24, occupies rdata[8 +: CNT_WIDTH])
// PORTS
//  clk_i       in   1             clock
//  rst_i       in   1             asynchronous reset, active-high
//  req_i       in   1             bus request
//  addr_i      in   ADDR_WIDTH    byte address
//  we_i        in   1             1 = write, 0 = read
//  wdata_i     in   32            write data
//  be_i        in   4             byte enables
//  gnt_o       out  1             grant (combinational, = req_i)
//  rvalid_o    out  1             response valid, one cycle after granted req
//  rdata_o     out  32            read data (0 for writes and errors)
//  err_o       out  1             decode error, qualified by rvalid_o
//  hw_start_i  in   NUM_STATUS    per-channel start pulse
//  hw_done_i   in   NUM_STATUS    per-channel done pulse
//  state_o     out  NUM_STATUS    per-channel state (1 = BUSY)
//  irq_o       out  1             OR of (done & irq_en) over all channels
// BEHAVIOUR
//  - One clock, clk_i; reset asynchronous, active-high on rst_i. Reset: all channels IDLE,
//    busy_cnt=0, done=0, irq_en=0; rvalid_o=0, rdata_o=0, err_o=0, irq_o=0, state_o=0.
//  - Register word per channel: [0] state RO, [1] done W1C, [2] irq_en RW, [7:3] RAZ/WI,
//    [8 +: CNT_WIDTH] busy_cnt RO, rest RAZ.
//  - Decode: off = addr_i - BASE_ADDR; hit when addr_i >= BASE_ADDR, off < NUM_STATUS*STRIDE,
//    off[1:0]==0; idx = off/STRIDE. Miss -> err_o=1 in response cycle, rdata_o=0, no state change.
//  - Latency: granted req in cycle N -> rvalid_o=1 in N+1 for exactly one cycle; back-to-back
//    requests every cycle supported. Read data sampled in cycle N (pre-update values).
//  - Writes: take effect at end of cycle N; be_i[0] gates bits [2:1]; other bytes ignored.
//  - Channel FSM: IDLE --hw_start--> BUSY, busy_cnt cleared to 0 on entry.
//    BUSY: busy_cnt += 1 each cycle, saturates at all-ones; hw_done -> IDLE, done<=1.
//    hw_done in IDLE ignored; hw_start in BUSY ignored (no restart, counter continues).
//  - Simultaneous: IDLE start+done -> BUSY (start wins). BUSY start+done -> IDLE, done=1.
//    HW done-set and SW W1C same cycle -> done stays 1 (set wins).
//  - irq_o registered-free: combinational OR of done & irq_en (no glitches from bus inputs).
//  - Reset asserted mid-operation: all state returns to reset values immediately; any
//    in-flight response is dropped (no rvalid_o after reset release for pre-reset req).
// STRUCTURE
//  - Shared package status_array_pkg: state_e (IDLE=1'd0, BUSY=1'd1), STATUS_STRIDE, field
//    offsets/masks (STATE_BIT, DONE_BIT, IRQ_EN_BIT, CNT_LSB), function returning channel
//    byte address for idx.
//  - Sub-module status_channel: one FSM + saturating counter + done/irq_en flops, with
//    done_clr/irq_en_we/irq_en_wdata inputs; top generates NUM_STATUS instances plus decoder
//    and response register.
// TESTING
//  - Reset: rst_i=1 mid-BUSY on ch0 -> state_o=0, irq_o=0, read ch0 after release -> 32'h0.
//  - start ch1, wait 10 cycles, read 0x4 -> rvalid next cycle, rdata[0]=1, rdata[31:8]>=10.
//  - done ch1 then read -> rdata[1:0]=2'b10; write 0x4 wdata=32'h2 be=4'h1 -> done cleared.
//  - write irq_en=1 (32'h4) ch0, start+done ch0 -> irq_o=1; W1C same cycle as hw_done -> stays 1.
//  - read 0x8 with NUM_STATUS=2, and 0x2 -> err_o=1, rdata_o=0; no register changes.
//  - CNT_WIDTH=4: BUSY 20 cycles -> busy_cnt=4'hF (saturated); start+done in IDLE -> BUSY.

Source files
------------

// File: rtl/status_array_pkg.sv
`default_nettype none
// ============================================================================
// Module : status_array_pkg
// Brief  : Shared types and field layout for the status register array.
//          Channel state encoding, word field offsets, channel stride and a
//          helper returning a channel's byte address.
// Rev    : 1.0  initial release
// ============================================================================
package status_array_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'd0,
    BUSY = 1'd1
  } state_e;

  // Each channel occupies one 32-bit word.
  localparam int unsigned STATUS_STRIDE = 4;

  // Field positions inside a channel word.
  localparam int unsigned STATE_BIT  = 0;
  localparam int unsigned DONE_BIT   = 1;
  localparam int unsigned IRQ_EN_BIT = 2;
  localparam int unsigned CNT_LSB    = 8;

  // Byte address of channel idx given the array base address.
  function automatic logic [63:0] chan_addr(input logic [63:0] base, input int unsigned idx);
    return base + (64'(idx) * 64'(STATUS_STRIDE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/status_array_regs_if.sv
`default_nettype none
// ============================================================================
// Module : status_array_regs_if
// Brief  : req/gnt/rvalid register bus.
//          master drives req, addr, we, wdata, be;
//          slave drives gnt, rvalid, rdata, err (err qualified by rvalid).
// Rev    : 1.0  initial release
// ============================================================================
interface status_array_regs_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic                  err;

  modport master (
    output req, addr, we, wdata, be,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, wdata, be,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/status_channel.sv
`default_nettype none
// ============================================================================
// Module : status_channel
// Brief  : One status channel: IDLE/BUSY state machine, saturating busy-cycle
//          counter, sticky done flag and interrupt enable flop.
// Ports  : clk_i, rst_i (async, active-high)
//          hw_start, hw_done      hardware pulses
//          done_clr               software W1C of done
//          irq_en_we/irq_en_wdata software write of irq_en
//          state, done, irq_en, busy_cnt   current channel status
// Rev    : 1.0  initial release
// ============================================================================
module status_channel
  import status_array_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hw_start,
  input  logic                 hw_done,
  input  logic                 done_clr,
  input  logic                 irq_en_we,
  input  logic                 irq_en_wdata,
  output state_e               state,
  output logic                 done,
  output logic                 irq_en,
  output logic [CNT_WIDTH-1:0] busy_cnt
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_cnt <= '0;
      done     <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (irq_en_we) begin
        irq_en <= irq_en_wdata;
      end

      case (state)
        IDLE: begin
          // done in IDLE is ignored, so start alone decides the transition.
          if (hw_start) begin
            state    <= BUSY;
            busy_cnt <= '0;
          end
        end
        BUSY: begin
          // start while BUSY is ignored; the counter keeps running.
          if (hw_done) begin
            state <= IDLE;
          end
          if (busy_cnt != {CNT_WIDTH{1'b1}}) begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Hardware completion outranks a coincident software clear.
      if (state == BUSY && hw_done) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/status_array_regs.sv
`default_nettype none
// ============================================================================
// Module : status_array_regs
// Brief  : Register block exposing NUM_STATUS status channels on a
//          req/gnt/rvalid bus at BASE_ADDR, one 32-bit word per channel:
//          [0] state RO, [1] done W1C, [2] irq_en RW,
//          [8 +: CNT_WIDTH] busy_cnt RO, all other bits read as zero.
// Ports  : clk_i, rst_i (async, active-high)
//          bus          slave side of status_array_regs_if
//          hw_start_i   per-channel start pulses
//          hw_done_i    per-channel done pulses
//          state_o      per-channel state (1 = BUSY)
//          irq_o        OR of done & irq_en over all channels
// Rev    : 1.0  initial release
// ============================================================================
module status_array_regs
  import status_array_pkg::*;
#(
  parameter int unsigned NUM_STATUS = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter logic [63:0] STRIDE     = 64'h4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  status_array_regs_if.slave    bus,
  input  logic [NUM_STATUS-1:0] hw_start_i,
  input  logic [NUM_STATUS-1:0] hw_done_i,
  output logic [NUM_STATUS-1:0] state_o,
  output logic                  irq_o
);

  localparam int unsigned           IDX_W = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE  = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(64'(NUM_STATUS) * STRIDE);

  function automatic logic [31:0] pack_word(input logic st, input logic dn, input logic ie,
                                            input logic [CNT_WIDTH-1:0] cnt);
    logic [31:0] w;
    w                      = '0;
    w[STATE_BIT]           = st;
    w[DONE_BIT]            = dn;
    w[IRQ_EN_BIT]          = ie;
    w[CNT_LSB +: CNT_WIDTH] = cnt;
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Address decode. The extra MSB of the subtraction is the borrow, which
  // flags addresses below BASE without a separate magnitude compare.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] off;
  logic                  below;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic                  wr_sel;

  assign diff   = {1'b0, bus.addr} - {1'b0, BASE};
  assign below  = diff[ADDR_WIDTH];
  assign off    = diff[ADDR_WIDTH-1:0];
  assign hit    = !below && (off < SPAN) && (off[1:0] == 2'b00);
  assign idx    = off[IDX_W+1:2];
  // Only byte 0 carries writable fields.
  assign wr_sel = bus.req && bus.we && hit && bus.be[0];

  // --------------------------------------------------------------------------
  // Channels
  // --------------------------------------------------------------------------
  state_e               ch_state [NUM_STATUS];
  logic                 ch_done  [NUM_STATUS];
  logic                 ch_irqen [NUM_STATUS];
  logic [CNT_WIDTH-1:0] ch_cnt   [NUM_STATUS];
  logic [31:0]          words    [NUM_STATUS];
  logic [NUM_STATUS-1:0] irq_vec;

  for (genvar i = 0; i < NUM_STATUS; i++) begin : g_chan
    logic sel;
    assign sel = wr_sel && (idx == IDX_W'(i));

    status_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .hw_start     (hw_start_i[i]),
      .hw_done      (hw_done_i[i]),
      .done_clr     (sel && bus.wdata[DONE_BIT]),
      .irq_en_we    (sel),
      .irq_en_wdata (bus.wdata[IRQ_EN_BIT]),
      .state        (ch_state[i]),
      .done         (ch_done[i]),
      .irq_en       (ch_irqen[i]),
      .busy_cnt     (ch_cnt[i])
    );

    assign state_o[i] = (ch_state[i] == BUSY);
    assign irq_vec[i] = ch_done[i] & ch_irqen[i];
    assign words[i]   = pack_word(state_o[i], ch_done[i], ch_irqen[i], ch_cnt[i]);
  end

  assign irq_o = |irq_vec;

  // --------------------------------------------------------------------------
  // Read mux: reflects values before this cycle's updates take effect.
  // --------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_word = words[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response register: one rvalid cycle per granted request.
  // --------------------------------------------------------------------------
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= bus.req;
      rsp_err   <= bus.req && !hit;
      rsp_data  <= (bus.req && !bus.we && hit) ? rd_word : '0;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rsp_valid;
  assign bus.rdata  = rsp_data;
  assign bus.err    = rsp_err;

  // Bits with no register behind them.
  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:3], bus.wdata[0], bus.be[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_status_array_regs.sv
`default_nettype none
// ============================================================================
// Module : tb_status_array_regs
// Brief  : Self-checking bench for status_array_regs (NUM_STATUS=2,
//          CNT_WIDTH=4). Directed steps push expected responses into a
//          scoreboard; a monitor pops and compares them when rvalid appears.
// Rev    : 1.0  initial release
// ============================================================================
module tb_status_array_regs;
  import status_array_pkg::*;

  localparam int unsigned NS = 2;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] hw_start;
  logic [NS-1:0] hw_done;
  logic [NS-1:0] state;
  logic          irq;

  status_array_regs_if #(.ADDR_WIDTH(64)) bus ();

  status_array_regs #(
    .NUM_STATUS (NS),
    .BASE_ADDR  (64'h0),
    .STRIDE     (64'h4),
    .ADDR_WIDTH (64),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .hw_start_i (hw_start),
    .hw_done_i  (hw_done),
    .state_o    (state),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc;
  int  n_checks;
  int  n_fail;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk({e.tag, " rvalid"}, 32'(bus.rvalid), 32'd1);
        chk({e.tag, " rdata"}, bus.rdata, e.rdata);
        chk({e.tag, " err"}, 32'(bus.err), 32'(e.err));
      end else if (bus.rvalid !== 1'b0) begin
        chk("unexpected rvalid", 32'(bus.rvalid), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NS-1:0] s, input logic [NS-1:0] d);
    hw_start = s;
    hw_done  = d;
    tick(1);
    hw_start = '0;
    hw_done  = '0;
  endtask

  task automatic bus_op(input string tag, input logic [63:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] exp_rd, input logic exp_err);
    sb_t e;
    bus.req   = 1'b1;
    bus.addr  = a;
    bus.we    = w;
    bus.wdata = wd;
    bus.be    = b;
    e.tag     = tag;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.cyc     = cyc + 1;
    sb.push_back(e);
    #1;
    chk({tag, " gnt"}, 32'(bus.gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    bus.be    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    hw_start  = '0;
    hw_done   = '0;
    bus.req   = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    bus.be    = '0;

    // Reset values
    tick(3);
    chk("rst state", 32'(state), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst rdata", bus.rdata, 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick(1);

    // Back-to-back reads of idle channels
    bus_op("rd ch0 init", chan_addr(64'h0, 0), 1'b0, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
    bus_op("rd ch1 init", chan_addr(64'h0, 1), 1'b0, 32'h0, 4'hF, 32'h0000_0000, 1'b0);

    // ch1 busy for 10 counted cycles
    pulse(2'b10, 2'b00);
    chk("ch1 busy state", 32'(state), 32'd2);
    tick(10);
    bus_op("rd ch1 busy", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0A01, 1'b0);
    pulse(2'b00, 2'b10);
    chk("ch1 idle state", 32'(state), 32'd0);
    chk("irq masked", 32'(irq), 32'd0);
    bus_op("rd ch1 done", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0C02, 1'b0);
    // Upper byte enables alone change nothing
    bus_op("wr ch1 be hi", 64'h4, 1'b1, 32'h6, 4'hE, 32'h0, 1'b0);
    bus_op("rd ch1 be hi", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0C02, 1'b0);
    bus_op("w1c ch1", 64'h4, 1'b1, 32'h2, 4'h1, 32'h0, 1'b0);
    bus_op("rd ch1 clr", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0C00, 1'b0);

    // Interrupt on ch0
    bus_op("wr ch0 irqen", 64'h0, 1'b1, 32'h4, 4'h1, 32'h0, 1'b0);
    bus_op("rd ch0 irqen", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0004, 1'b0);
    pulse(2'b01, 2'b00);
    chk("irq while busy", 32'(irq), 32'd0);
    pulse(2'b00, 2'b01);
    chk("irq after done", 32'(irq), 32'd1);
    bus_op("rd ch0 done", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0106, 1'b0);

    // W1C coincident with hw_done: set wins
    pulse(2'b01, 2'b00);
    hw_done = 2'b01;
    bus_op("w1c vs done", 64'h0, 1'b1, 32'h6, 4'h1, 32'h0, 1'b0);
    hw_done = 2'b00;
    chk("irq set wins", 32'(irq), 32'd1);
    bus_op("rd ch0 setwin", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0106, 1'b0);
    bus_op("w1c ch0", 64'h0, 1'b1, 32'h6, 4'h1, 32'h0, 1'b0);
    chk("irq cleared", 32'(irq), 32'd0);

    // Decode errors leave registers untouched
    bus_op("rd 0x8", 64'h8, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_op("wr 0x8", 64'h8, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_op("rd 0x2", 64'h2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_op("wr 0x2", 64'h2, 1'b1, 32'h0, 4'h1, 32'h0, 1'b1);
    bus_op("rd high", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_op("rd ch0 post err", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0104, 1'b0);
    bus_op("rd ch1 post err", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0C00, 1'b0);

    // Counter saturation and start ignored while BUSY
    pulse(2'b10, 2'b00);
    tick(20);
    bus_op("rd ch1 sat", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0F01, 1'b0);
    pulse(2'b10, 2'b00);
    bus_op("rd ch1 restart", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0000_0F01, 1'b0);
    pulse(2'b00, 2'b10);

    // start+done in IDLE -> BUSY; start+done in BUSY -> IDLE with done
    pulse(2'b01, 2'b01);
    chk("idle start+done", 32'(state), 32'd1);
    chk("idle s+d irq", 32'(irq), 32'd0);
    bus_op("rd ch0 sd idle", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0005, 1'b0);
    pulse(2'b01, 2'b01);
    chk("busy start+done", 32'(state), 32'd0);
    chk("busy s+d irq", 32'(irq), 32'd1);
    bus_op("rd ch0 sd busy", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0000_0206, 1'b0);

    // Reset mid-BUSY with a request in flight: response is dropped
    pulse(2'b01, 2'b00);
    tick(3);
    bus.req  = 1'b1;
    bus.addr = 64'h0;
    bus.we   = 1'b0;
    bus.be   = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst state", 32'(state), 32'd0);
    chk("midrst irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    bus_op("rd ch0 after rst", 64'h0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    bus_op("rd ch1 after rst", 64'h4, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    chk("irq after rst", 32'(irq), 32'd0);

    tick(3);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
